// File: rtl/adder_split_pkg.sv
//==============================================================================
// Module      : adder_split_pkg
// Description : Shared types and constants for the adder result splitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package adder_split_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int C_DEFAULT_WIDTH = 8;
    localparam int C_CNT_W         = $clog2(C_DEFAULT_WIDTH + 1);

    // Bit counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sub_cell.sv
//==============================================================================
// Module      : serial_sub_cell
// Description : One-bit full subtractor (a - b - borrow_in) with a registered
//               borrow; borrow is the outgoing borrow of the current bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_sub_cell (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic a,
    input  logic b,
    output logic d,
    output logic borrow
);

    logic r_borrow;

    assign d      = a ^ b ^ r_borrow;
    assign borrow = (~a & b) | (~(a ^ b) & r_borrow);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_borrow <= 1'b0;
        end else if (clear) begin
            r_borrow <= 1'b0;
        end else if (enable) begin
            r_borrow <= borrow;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_result_splitter.sv
//==============================================================================
// Module      : adder_result_splitter
// Description : Recovers out = sum - in1 by LSB-first bit-serial subtraction.
//               Define ADDER_SPLIT_SAT_EN for a saturating result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adder_result_splitter
    import adder_split_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    localparam int                 C_CW   = cnt_width(WIDTH);
    localparam logic [C_CW-1:0]    c_last = C_CW'(WIDTH);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out;
    logic              r_err;
    logic [WIDTH:0]    r_a;
    logic [WIDTH:0]    r_b;
    logic [WIDTH-1:0]  r_diff;
    logic [C_CW-1:0]   r_count;

    logic              w_accept;
    logic              w_shift;
    logic              w_d;
    logic              w_borrow;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_result;

    assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_shift  = (r_state == SHIFT);

    serial_sub_cell u_cell (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept),
        .enable (w_shift),
        .a      (r_a[0]),
        .b      (r_b[0]),
        .d      (w_d),
        .borrow (w_borrow)
    );

    // Complete difference as seen during the final shift cycle.
    assign w_diff = {w_d, r_diff};

`ifdef ADDER_SPLIT_SAT_EN
    always_comb begin
        w_result = w_diff[WIDTH-1:0];
        if (w_borrow) begin
            w_result = '0;
        end else if (w_diff[WIDTH]) begin
            w_result = '1;
        end
    end
`else
    assign w_result = w_diff[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_err       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_a        <= sum;
                        r_b        <= {1'b0, in1};
                        r_diff     <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_count <= r_count + C_CW'(1);
                    if (r_count == c_last) begin
                        r_out       <= w_result;
                        r_err       <= w_borrow | w_diff[WIDTH];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adder_result_splitter.sv
//==============================================================================
// Module      : tb_adder_result_splitter
// Description : Scoreboard bench for adder_result_splitter (WIDTH=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adder_result_splitter;

    typedef struct {
        logic [7:0] o;
        logic       e;
        int         acc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] sum;
    logic [7:0] in1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       err;

    exp_t       q[$];
    int         checks;
    int         errors;
    int         cyc;
    logic       prev_valid;

    adder_result_splitter #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: latency on rising out_valid, value check at each handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    if (!prev_valid) check("latency", cyc - q[0].acc, 9);
                    if (out_ready) begin
                        check("out", int'(out), int'(q[0].o));
                        check("err", int'(err), int'(q[0].e));
                        void'(q.pop_front());
                    end
                end
            end
            prev_valid <= out_valid & ~out_ready;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic send(input logic [8:0] s, input logic [7:0] a,
                        input logic [7:0] eo, input logic ee);
        exp_t x;
        int   n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        sum      = s;
        in1      = a;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            x.o = eo; x.e = ee; x.acc = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sum      = 9'($urandom);
        in1      = 8'($urandom);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 60);
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        prev_valid = 1'b0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        sum        = '0;
        in1        = '0;
        out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("in_ready_in_reset", int'(in_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_err", int'(err), 0);

        send(9'd7, 8'd5, 8'd2, 1'b0);
        wait_valid();
        @(negedge clk);
        check("in_ready_after_hs", int'(in_ready), 1);
        check("valid_drop_after_hs", int'(out_valid), 0);

        send(9'd510, 8'd255, 8'd255, 1'b0);
        send(9'd0, 8'd0, 8'd0, 1'b0);
`ifdef ADDER_SPLIT_SAT_EN
        send(9'd3, 8'd5, 8'h00, 1'b1);
        send(9'd300, 8'd10, 8'hFF, 1'b1);
`else
        send(9'd3, 8'd5, 8'hFE, 1'b1);
        send(9'd300, 8'd10, 8'h22, 1'b1);
`endif
        drain();

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        send(9'd100, 8'd58, 8'd42, 1'b0);
        wait_valid();
        in_valid = 1'b1;
        sum      = 9'd9;
        in1      = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out", int'(out), 42);
            check("stall_err", int'(err), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (15) @(negedge clk);

        // Asynchronous reset in the middle of a shift.
        send(9'd7, 8'd5, 8'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        #1;
        check("midrst_out", int'(out), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        send(9'd7, 8'd5, 8'd2, 1'b0);
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_result_splitter.md
Name: adder_result_splitter

Overview:
- Inverse-direction companion to the registered 8-bit adder: takes a 9-bit sum and one 8-bit addend, and recovers the other addend as out = sum - in1.
- Bit-serial subtraction, LSB first, one bit per clock, behind valid/ready handshakes on both sides.
- Sits downstream of the adder as a result checker and operand-recovery stage; also provides a low-area subtract path.

Parameters:
- WIDTH, 8, operand width; sum input is WIDTH+1 bits, result is WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 resets)
- in_valid  input  1  sum/in1 valid
- in_ready  output  1  block can accept an operation
- sum  input  WIDTH+1  minuend (adder output)
- in1  input  WIDTH  subtrahend (known addend)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  recovered addend
- err  output  1  result not representable in WIDTH bits (negative or > 2^WIDTH-1)

Behaviour:
- Reset values (asynchronous, reset=0): state=IDLE, in_ready=0 while reset is held and 1 from the first edge after release; out_valid=0, out=0, err=0; shift registers, borrow and bit counter all 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0: capture sum into a WIDTH+1 shift register and zero-extended in1 into a WIDTH+1 shift register; borrow=0, count=0; go to SHIFT.
  - SHIFT: in_ready=0. Each edge: d = a0 ^ b0 ^ borrow; borrow' = (~a0&b0) | (~(a0^b0)&borrow). d shifts into the MSB of the result register; both operand registers shift right; count++. At count==WIDTH, i.e. edge E0+WIDTH+1, go to DONE.
  - DONE: out_valid=1; out and err registered and stable. Hold while out_ready=0. On out_valid&&out_ready, go to IDLE; out_valid drops at that edge.
- Latency: out_valid is high in the cycle after edge E0+WIDTH+1, i.e. 9 cycles for WIDTH=8. in_ready rises the cycle after the output handshake.
- Throughput: one operation per WIDTH+3 cycles minimum. There is no overlap; in_valid is ignored outside IDLE.
- Arithmetic:
  - diff[WIDTH:0] is the serial result.
  - err = final borrow | diff[WIDTH].
  - out = diff[WIDTH-1:0] (default wrap behaviour).
- Inputs sum and in1 are sampled only at the accept edge; later changes have no effect.
- Reset mid-SHIFT or mid-DONE: the operation is discarded and all outputs return to reset values immediately (asynchronous).
- out_ready high while not out_valid: ignored.
- sum=0, in1=0: out=0, err=0, full latency still applies (no early exit).

Optional Feature:
- Macro: ADDER_SPLIT_SAT_EN
- Defined: saturating result.
  - Final borrow=1 (negative): out=0.
  - diff[WIDTH]=1 with no borrow (overflow): out = all ones.
  - err is unchanged.
- Undefined: out = wrapped low WIDTH bits of diff; no saturation logic is compiled.

Decomposition:
- Package adder_split_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - default WIDTH constant
  - counter width localparam, $clog2(WIDTH+1)
- Sub-module serial_sub_cell: one-bit full subtractor with a registered borrow flop (clk, reset, clear, enable, a, b, d, borrow). Instantiated once by the FSM top.

Test Plan:
- Reset release with no input -> in_ready=1 after the first edge; out_valid=0, out=0, err=0.
- sum=7, in1=5, out_ready=1 -> out_valid after 9 cycles with out=2, err=0; in_ready high the cycle after the handshake.
- sum=510, in1=255 -> out=255, err=0; sum=0, in1=0 -> out=0, err=0.
- sum=3, in1=5 (negative result) -> err=1; out=0xFE with the macro undefined, out=0x00 with ADDER_SPLIT_SAT_EN defined.
- sum=300, in1=10 (result 290, too large) -> err=1; out=0x22 with the macro undefined, 0xFF with it defined.
- Back-pressure and reset:
  - out_ready=0 for 5 cycles in DONE -> out and err stable, in_ready=0, new in_valid ignored.
  - reset=0 during SHIFT at cycle 4 -> all outputs 0 immediately; after release, a fresh sum=7, in1=5 completes with out=2.
